muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO result registers: iterative shift-add multiply,
// restoring divide. Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic         annul,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         dbz
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [2:0] {
    OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2, OP_DIVU = 3'd3,
    OP_MTHI = 3'd4, OP_MTLO  = 3'd5, OP_NOP6 = 3'd6, OP_NOP7 = 3'd7
  } op_t;

  state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [W-1:0] opb, opb_nx;        // multiplicand or divisor magnitude
  logic [W:0]   acc_hi, acc_hi_nx;  // partial product high half or remainder
  logic [W-1:0] acc_lo, acc_lo_nx;  // multiplier or dividend/quotient
  logic         neg_q, neg_q_nx;
  logic         neg_r, neg_r_nx;
  logic [W-1:0] hi_nx, lo_nx;
  logic         done_nx, dbz_nx;

  op_t          op_e;
  logic         is_signed;
  logic [W-1:0] mag1, mag2;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_prod;
  logic [W:0]   div_sh, div_diff, div_rem_n;
  logic         div_ok;
  logic [W-1:0] div_quo_n;
  logic         last;

  assign op_e      = op_t'(op);
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign mag1      = (is_signed && src1[W-1]) ? -src1 : src1;
  assign mag2      = (is_signed && src2[W-1]) ? -src2 : src2;
  assign busy      = (state != S_IDLE);
  assign last      = (cnt == CNT_W'(W-1));

  // One shift-add step: the product shifts right through {acc_hi, acc_lo}.
  assign mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opb} : '0);
  assign mul_prod = {mul_sum, acc_lo[W-1:1]};

  // One restoring-divide step: the dividend shifts out of acc_lo into the remainder.
  assign div_sh    = {acc_hi[W-1:0], acc_lo[W-1]};
  assign div_ok    = (div_sh >= {1'b0, opb});
  assign div_diff  = div_sh - {1'b0, opb};
  assign div_rem_n = div_ok ? div_diff : div_sh;
  assign div_quo_n = {acc_lo[W-2:0], div_ok};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  logic           fast_neg;
  assign fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
  assign fast_neg  = (op_e == OP_MULT) && (src1[W-1] ^ src2[W-1]);
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    opb_nx    = opb;
    acc_hi_nx = acc_hi;
    acc_lo_nx = acc_lo;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    hi_nx     = hi;
    lo_nx     = lo;
    done_nx   = 1'b0;
    dbz_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !annul) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_nx, lo_nx} = fast_neg ? -fast_prod : fast_prod;
              done_nx        = 1'b1;
`else
              state_nx  = S_MUL;
              cnt_nx    = '0;
              opb_nx    = mag2;
              acc_hi_nx = '0;
              acc_lo_nx = mag1;
              neg_q_nx  = is_signed && (src1[W-1] ^ src2[W-1]);
              neg_r_nx  = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (src2 == '0) begin
                hi_nx   = src1;
                lo_nx   = '1;
                done_nx = 1'b1;
                dbz_nx  = 1'b1;
              end else begin
                state_nx  = S_DIV;
                cnt_nx    = '0;
                opb_nx    = mag2;
                acc_hi_nx = '0;
                acc_lo_nx = mag1;
                neg_q_nx  = is_signed && (src1[W-1] ^ src2[W-1]);
                neg_r_nx  = is_signed && src1[W-1];
              end
            end
            OP_MTHI: begin
              hi_nx   = src1;
              done_nx = 1'b1;
            end
            OP_MTLO: begin
              lo_nx   = src1;
              done_nx = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (annul) begin
          state_nx = S_IDLE;
        end else begin
          acc_hi_nx = {1'b0, mul_sum[W:1]};
          acc_lo_nx = {mul_sum[0], acc_lo[W-1:1]};
          cnt_nx    = cnt + CNT_W'(1);
          if (last) begin
            state_nx       = S_IDLE;
            {hi_nx, lo_nx} = neg_q ? -mul_prod : mul_prod;
            done_nx        = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (annul) begin
          state_nx = S_IDLE;
        end else begin
          acc_hi_nx = div_rem_n;
          acc_lo_nx = div_quo_n;
          cnt_nx    = cnt + CNT_W'(1);
          if (last) begin
            state_nx = S_IDLE;
            lo_nx    = neg_q ? -div_quo_n : div_quo_n;
            hi_nx    = neg_r ? -div_rem_n[W-1:0] : div_rem_n[W-1:0];
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      opb    <= opb_nx;
      acc_hi <= acc_hi_nx;
      acc_lo <= acc_lo_nx;
      neg_q  <= neg_q_nx;
      neg_r  <= neg_r_nx;
      hi     <= hi_nx;
      lo     <= lo_nx;
      done   <= done_nx;
      dbz    <= dbz_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at W=32: directed vector table plus
// hand sequences for MTHI/MTLO, annul, start-while-busy, back-to-back and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        annul;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .src1(src1), .src2(src2),
    .annul(annul), .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_DONE = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_DONE = 33;
  localparam int MUL_BUSY = 32;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[17];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accept edge until done is seen; dc stays -1 on timeout.
  task automatic wait_done(input int limit, output int dc, output int bc, output logic dz);
    dc = -1; bc = 0; dz = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc = k;
        dz = dbz;
        break;
      end
    end
  endtask

  function automatic int exp_done(input logic [2:0] o, input logic [31:0] b);
    if (o <= 3'd1) return MUL_DONE;
    if (o <= 3'd3) return (b == 32'd0) ? 1 : 33;
    return 1;
  endfunction

  function automatic int exp_busy(input logic [2:0] o, input logic [31:0] b);
    if (o <= 3'd1) return MUL_BUSY;
    if (o <= 3'd3) return (b == 32'd0) ? 0 : 32;
    return 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc, bc;
    logic dz;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[5]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{3'd0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[8]  = '{3'd2, 32'h80000000, 32'h00000007, 32'hFFFFFFFE, 32'hEDB6DB6E, 1'b0};
    vecs[9]  = '{3'd2, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0};
    vecs[10] = '{3'd2, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    vecs[11] = '{3'd0, 32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0};
    vecs[12] = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[13] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[14] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{3'd3, 32'd5,        32'hFFFFFFFF, 32'd5,        32'd0,        1'b0};
    vecs[16] = '{3'd1, 32'd0,        32'h00012345, 32'd0,        32'd0,        1'b0};

    rstn = 1'b0; start = 1'b0; annul = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(dbz), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(60, dc, bc, dz);
      chk($sformatf("v%0d done_cycle", i), 64'(dc), 64'(exp_done(vecs[i].op, vecs[i].b)));
      chk($sformatf("v%0d busy_cycles", i), 64'(bc), 64'(exp_busy(vecs[i].op, vecs[i].b)));
      chk($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("v%0d dbz", i), 64'(dz), 64'(vecs[i].dbz));
      @(negedge clk);
      chk($sformatf("v%0d done_after", i), 64'(done), 64'd0);
      chk($sformatf("v%0d dbz_after", i), 64'(dbz), 64'd0);
    end

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'hAAAA0000;
    @(negedge clk);
    chk("mthi done", 64'(done), 64'd1);
    chk("mthi hi", 64'(hi), 64'hAAAA0000);
    chk("mthi busy", 64'(busy), 64'd0);
    op = 3'd5; src1 = 32'h00005555;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo done", 64'(done), 64'd1);
    chk("mtlo lo", 64'(lo), 64'h00005555);
    chk("mtlo hi", 64'(hi), 64'hAAAA0000);
    chk("mtlo busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("mtlo done_after", 64'(done), 64'd0);

    // start together with annul in IDLE is ignored
    start = 1'b1; annul = 1'b1; op = 3'd4; src1 = 32'h00012345;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    chk("annul_start done", 64'(done), 64'd0);
    chk("annul_start hi", 64'(hi), 64'hAAAA0000);

    // op 6 is a no-op
    start = 1'b1; op = 3'd6; src1 = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    chk("nop done", 64'(done), 64'd0);
    chk("nop busy", 64'(busy), 64'd0);
    chk("nop lo", 64'(lo), 64'h00005555);

    // annul mid-divide: no done, hi/lo untouched, then a clean divide
    issue(3'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    chk("annul busy_before", 64'(busy), 64'd1);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul busy_after", 64'(busy), 64'd0);
    wait_done(40, dc, bc, dz);
    chk("annul no_done", 64'(dc == -1), 64'd1);
    chk("annul hi", 64'(hi), 64'hAAAA0000);
    chk("annul lo", 64'(lo), 64'h00005555);
    issue(3'd3, 32'd100, 32'd7);
    wait_done(60, dc, bc, dz);
    chk("post_annul done_cycle", 64'(dc), 64'd33);
    chk("post_annul lo", 64'(lo), 64'd14);
    chk("post_annul hi", 64'(hi), 64'd2);

    // start while busy is ignored
    issue(3'd3, 32'd200, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, dc, bc, dz);
    chk("busy_start done_cycle", 64'(dc), 64'd27);
    chk("busy_start lo", 64'(lo), 64'd28);
    chk("busy_start hi", 64'(hi), 64'd4);

    // back-to-back: new request accepted in the done cycle
    issue(3'd1, 32'd3, 32'd5);
    wait_done(60, dc, bc, dz);
    chk("b2b first done_cycle", 64'(dc), 64'(MUL_DONE));
    chk("b2b first lo", 64'(lo), 64'd15);
    chk("b2b first hi", 64'(hi), 64'd0);
    start = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, dc, bc, dz);
    chk("b2b second done_cycle", 64'(dc), 64'd33);
    chk("b2b second lo", 64'(lo), 64'd14);
    chk("b2b second hi", 64'(hi), 64'd2);

    // asynchronous reset mid-divide
    issue(3'd2, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset dbz", 64'(dbz), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    wait_done(40, dc, bc, dz);
    chk("midreset no_done", 64'(dc == -1), 64'd1);
    chk("midreset no_busy", 64'(bc), 64'd0);
    chk("midreset lo_after", 64'(lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
